// File: rtl/brick_scan_detect.sv
// Sequential brick-field collision scanner: latches one ball on start, walks the bricks one per
// cycle, kills the first live brick it overlaps and reports its index and the face struck.
module brick_scan_detect #(
  parameter int COLS    = 8,
  parameter int ROWS    = 4,
  parameter int COORD_W = 10,
  parameter int R_W     = 6,
  parameter int X0      = 40,
  parameter int Y0      = 40,
  parameter int PITCH_X = 70,
  parameter int PITCH_Y = 24,
  parameter int HALF_W  = 32,
  parameter int HALF_H  = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [COORD_W-1:0]                 ball_x,
  input  logic [COORD_W-1:0]                 ball_y,
  input  logic [R_W-1:0]                     ball_r,
  input  logic                               load_all,
  output logic                               busy,
  output logic                               done,
  output logic                               hit,
  output logic [$clog2(COLS*ROWS)-1:0]       hit_idx,
  output logic [1:0]                         direction,
  output logic [COLS*ROWS-1:0]               alive,
  output logic [$clog2(COLS*ROWS+1)-1:0]     bricks_left
);

  localparam int N     = COLS * ROWS;
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(N + 1);
  // Two guard bits so no sum of coordinate, radius and half-size can wrap.
  localparam int SUM_W = COORD_W + 2;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [COORD_W-1:0] bx_r;
  logic [COORD_W-1:0] by_r;
  logic [R_W-1:0]     br_r;

  logic [IDX_W-1:0]   col_s;
  logic [IDX_W-1:0]   row_s;
  logic [SUM_W-1:0]   wx_s;
  logic [SUM_W-1:0]   wy_s;
  logic [SUM_W-1:0]   bx_s;
  logic [SUM_W-1:0]   by_s;
  logic [SUM_W-1:0]   r_s;
  logic [SUM_W-1:0]   h_s;
  logic [SUM_W-1:0]   hw_s;
  logic [SUM_W-1:0]   hh_s;
  logic               rx_s;
  logic               ry_s;
  logic               overlap_s;
  logic [1:0]         face_s;

  // Geometry of the brick under test against the latched ball: overlap and struck face.
  always_comb begin
    col_s  = IDX_W'(idx_r % COLS);
    row_s  = IDX_W'(idx_r / COLS);
    wx_s   = SUM_W'(X0) + SUM_W'(col_s) * SUM_W'(PITCH_X);
    wy_s   = SUM_W'(Y0) + SUM_W'(row_s) * SUM_W'(PITCH_Y);
    bx_s   = SUM_W'(bx_r);
    by_s   = SUM_W'(by_r);
    r_s    = SUM_W'(br_r);
    h_s    = r_s >> 1;
    hw_s   = SUM_W'(HALF_W);
    hh_s   = SUM_W'(HALF_H);
    rx_s   = (bx_s < r_s + wx_s + hw_s) && (bx_s + r_s + hw_s >= wx_s);
    ry_s   = (by_s < r_s + wy_s + hh_s) && (by_s + r_s + hh_s >= wy_s);
    overlap_s = rx_s && ry_s && alive[idx_r];
    if ((bx_s < wx_s) && (bx_s + h_s + hw_s < wx_s)) begin
      face_s = DIR_LEFT;
    end else if ((bx_s > wx_s) && (bx_s > h_s + wx_s + hw_s)) begin
      face_s = DIR_RIGHT;
    end else if (by_s < wy_s) begin
      face_s = DIR_UP;
    end else begin
      face_s = DIR_DOWN;
    end
  end

  // Scan FSM, brick mask and result registers; load_all overrides everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= {IDX_W{1'b0}};
      bx_r        <= {COORD_W{1'b0}};
      by_r        <= {COORD_W{1'b0}};
      br_r        <= {R_W{1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      hit         <= 1'b0;
      hit_idx     <= {IDX_W{1'b0}};
      direction   <= DIR_UP;
      alive       <= {N{1'b1}};
      bricks_left <= CNT_W'(N);
    end else if (load_all) begin
      state_r     <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      alive       <= {N{1'b1}};
      bricks_left <= CNT_W'(N);
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            bx_r    <= ball_x;
            by_r    <= ball_y;
            br_r    <= ball_r;
            idx_r   <= {IDX_W{1'b0}};
            busy    <= 1'b1;
            state_r <= SCAN;
          end
        end
        SCAN: begin
          if (overlap_s) begin
            hit            <= 1'b1;
            hit_idx        <= idx_r;
            direction      <= face_s;
            alive[idx_r]   <= 1'b0;
            bricks_left    <= bricks_left - CNT_W'(1);
            busy           <= 1'b0;
            done           <= 1'b1;
            state_r        <= DONE;
          end else if (idx_r == IDX_W'(N - 1)) begin
            hit     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            idx_r <= idx_r + IDX_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
